// File: rtl/mem_responder.sv
// Purpose : multi-cycle data-memory responder for the load/store port of the 16-bit core.
// Latency : request accepted at edge t0 -> done pulse in cycle t0+LATENCY; load data valid with done.
// Backpr. : stall holds the core while a request waits in IDLE or is in BUSY; requests in BUSY/DONE are ignored.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset (memory array is not cleared)
//   req_rd   - load request, level
//   req_wr   - store request, level
//   addr     - byte address; word index = addr[ADDR_W:1], upper bits ignored
//   data_in  - store data
//   data_out - registered load data, held until the next load completes
//   stall    - core must hold PC and request
//   done     - one-cycle completion pulse
//   busy     - high in BUSY and DONE
//   err      - one-cycle protocol-error pulse
//
// Build option: define MEM_ALIGN_CHECK_EN to reject odd byte addresses (access skipped,
// err raised together with done). Without it addr[0] is ignored.
module mem_responder #(
   parameter int LATENCY = 4,   // 1..15
   parameter int ADDR_W  = 10   // 1..14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        done,
   output logic        busy,
   output logic        err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
   localparam bit         LAT_ONE  = (LATENCY == 1);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_is_wr;
   logic              r_bad;
   logic [ADDR_W-1:0] r_idx;
   logic [15:0]       r_wdat;
   logic [15:0]       r_data_out;
   logic              r_err;
   logic [15:0]       r_mem [0:(2**ADDR_W)-1];

   logic              w_idle;
   logic              w_one_req;
   logic              w_both_req;
   logic              w_accept;
   logic              w_req_bad;
   logic              w_fire;
   logic              w_acc_wr;
   logic              w_acc_bad;
   logic [ADDR_W-1:0] w_acc_idx;
   logic [15:0]       w_acc_dat;
   logic              w_unused_addr;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_one_req  = req_rd ^ req_wr;
   assign w_both_req = req_rd & req_wr;
   assign w_accept   = w_idle & w_one_req;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_req_bad = addr[0];
`else
   assign w_req_bad = 1'b0;
`endif

   // Bits outside the word index never influence the access.
   assign w_unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

   // The access happens on the last edge before DONE. With LATENCY==1 that is the
   // accepting edge itself, so the live inputs are used instead of the latched copy.
   assign w_fire    = (w_accept & LAT_ONE) | ((r_state == ST_BUSY) & (r_cnt <= 4'd1));
   assign w_acc_wr  = w_idle ? req_wr           : r_is_wr;
   assign w_acc_bad = w_idle ? w_req_bad        : r_bad;
   assign w_acc_idx = w_idle ? addr[ADDR_W:1]   : r_idx;
   assign w_acc_dat = w_idle ? data_in          : r_wdat;

   // Memory array has no reset; a write coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (!rst && w_fire && w_acc_wr && !w_acc_bad) begin
         r_mem[w_acc_idx] <= w_acc_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_is_wr    <= 1'b0;
         r_bad      <= 1'b0;
         r_idx      <= '0;
         r_wdat     <= 16'h0000;
         r_data_out <= 16'h0000;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_both_req) begin
                  r_err <= 1'b1;
               end else if (w_one_req) begin
                  r_is_wr <= req_wr;
                  r_bad   <= w_req_bad;
                  r_idx   <= addr[ADDR_W:1];
                  r_wdat  <= data_in;
                  r_cnt   <= CNT_LOAD;
                  r_state <= LAT_ONE ? ST_DONE : ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         // Misaligned requests run the full latency but only report err with done.
         if (w_fire) begin
            if (w_acc_bad) begin
               r_err <= 1'b1;
            end else if (!w_acc_wr) begin
               r_data_out <= r_mem[w_acc_idx];
            end
         end
      end
   end

   assign stall    = !rst && ((w_idle && (req_rd || req_wr)) || (r_state == ST_BUSY));
   assign busy     = (r_state == ST_BUSY) || (r_state == ST_DONE);
   assign done     = (r_state == ST_DONE);
   assign data_out = r_data_out;
   assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses LATENCY=4, instance 1 uses LATENCY=1.
// Expected values come from a transaction-level model: a word-indexed associative
// memory, the last load value per instance, and the cycle count LATENCY.
module tb_mem_responder;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic [1:0]  rst_v;
   logic [1:0]  rd_v;
   logic [1:0]  wr_v;
   logic [1:0]  stall_v;
   logic [1:0]  done_v;
   logic [1:0]  busy_v;
   logic [1:0]  err_v;
   logic [15:0] addr_a [2];
   logic [15:0] din_a  [2];
   logic [15:0] dout_a [2];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] ref_mem [int];
   logic [15:0] exp_dout [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_responder #(.LATENCY((g == 0) ? 4 : 1), .ADDR_W(AW)) u_dut (
         .clk      (clk),
         .rst      (rst_v[g]),
         .req_rd   (rd_v[g]),
         .req_wr   (wr_v[g]),
         .addr     (addr_a[g]),
         .data_in  (din_a[g]),
         .data_out (dout_a[g]),
         .stall    (stall_v[g]),
         .done     (done_v[g]),
         .busy     (busy_v[g]),
         .err      (err_v[g])
      );
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   function automatic int key_of(input int u, input logic [15:0] a);
      return u * 65536 + int'(a[AW:1]);
   endfunction

   task automatic idle_chk(input int u);
      chk("idle_stall", {15'd0, stall_v[u]}, 16'd0);
      chk("idle_done",  {15'd0, done_v[u]},  16'd0);
      chk("idle_busy",  {15'd0, busy_v[u]},  16'd0);
      chk("idle_err",   {15'd0, err_v[u]},   16'd0);
      chk("idle_dout",  dout_a[u], exp_dout[u]);
   endtask

   // One complete transaction: accept cycle, LATENCY-1 busy cycles, done cycle.
   task automatic do_op(input int u, input bit is_wr, input logic [15:0] a,
                        input logic [15:0] d, input bit scramble);
      bit bad;
      int key;
      bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      bad = a[0];
`endif
      key = key_of(u, a);
      @(negedge clk);
      rd_v[u] = !is_wr; wr_v[u] = is_wr; addr_a[u] = a; din_a[u] = d;
      #1;
      chk("accept_stall", {15'd0, stall_v[u]}, 16'd1);
      chk("accept_busy",  {15'd0, busy_v[u]},  16'd0);
      for (int k = 1; k < lat_of(u); k++) begin
         @(negedge clk);
         chk("busy_stall", {15'd0, stall_v[u]}, 16'd1);
         chk("busy_busy",  {15'd0, busy_v[u]},  16'd1);
         chk("busy_done",  {15'd0, done_v[u]},  16'd0);
         chk("busy_err",   {15'd0, err_v[u]},   16'd0);
         if (scramble) begin
            rd_v[u] = 1'($urandom); wr_v[u] = 1'($urandom);
            addr_a[u] = 16'($urandom); din_a[u] = 16'($urandom);
         end
      end
      if (!bad) begin
         if (is_wr) ref_mem[key] = d;
         else exp_dout[u] = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
      end
      @(negedge clk);
      chk("done_done",  {15'd0, done_v[u]},  16'd1);
      chk("done_stall", {15'd0, stall_v[u]}, 16'd0);
      chk("done_busy",  {15'd0, busy_v[u]},  16'd1);
      chk("done_err",   {15'd0, err_v[u]},   {15'd0, bad});
      chk("done_dout",  dout_a[u], exp_dout[u]);
      rd_v[u] = 1'b0; wr_v[u] = 1'b0;
   endtask

   initial begin
      logic [15:0] a;
      int          widx;
      bit          wr;

      rst_v = 2'b11; rd_v = 2'b00; wr_v = 2'b00;
      for (int u = 0; u < 2; u++) begin
         addr_a[u] = 16'h0; din_a[u] = 16'h0; exp_dout[u] = 16'h0;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall0", {14'd0, stall_v}, 16'd0);
      @(negedge clk);
      rst_v = 2'b00;

      // Reset state over three idle cycles.
      repeat (3) begin
         @(negedge clk);
         idle_chk(0);
         idle_chk(1);
      end

      // Store then load one word; the store must not disturb data_out.
      do_op(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      do_op(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
      chk("rd_beef", exp_dout[0], 16'hBEEF);

      // Simultaneous load and store in IDLE: err pulse only.
      @(negedge clk);
      rd_v[0] = 1'b1; wr_v[0] = 1'b1; addr_a[0] = 16'h0010; din_a[0] = 16'h1111;
      #1 chk("both_stall", {15'd0, stall_v[0]}, 16'd1);
      @(negedge clk);
      chk("both_err",  {15'd0, err_v[0]},  16'd1);
      chk("both_busy", {15'd0, busy_v[0]}, 16'd0);
      chk("both_done", {15'd0, done_v[0]}, 16'd0);
      chk("both_dout", dout_a[0], exp_dout[0]);
      rd_v[0] = 1'b0; wr_v[0] = 1'b0;
      @(negedge clk);
      idle_chk(0);
      do_op(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
      chk("both_mem", dout_a[0], 16'hBEEF);

      // Store interrupted by reset must never commit.
      do_op(0, 1'b1, 16'h0020, 16'h5A5A, 1'b0);
      @(negedge clk);
      wr_v[0] = 1'b1; addr_a[0] = 16'h0020; din_a[0] = 16'h1234;
      @(negedge clk);
      @(negedge clk);
      rst_v[0] = 1'b1;
      #1 chk("rst_mid_stall", {15'd0, stall_v[0]}, 16'd0);
      @(negedge clk);
      rst_v[0] = 1'b0; wr_v[0] = 1'b0;
      exp_dout[0] = 16'h0000;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         idle_chk(0);
      end
      do_op(0, 1'b0, 16'h0020, 16'h0000, 1'b0);
      chk("rst_nocommit", dout_a[0], 16'h5A5A);

      // LATENCY=1: back-to-back loads, request held through the done cycle.
      do_op(1, 1'b1, 16'h0000, 16'h00AA, 1'b0);
      do_op(1, 1'b1, 16'h0002, 16'h0055, 1'b0);
      @(negedge clk);
      rd_v[1] = 1'b1; addr_a[1] = 16'h0000;
      #1 chk("l1_stall_a", {15'd0, stall_v[1]}, 16'd1);
      @(negedge clk);
      chk("l1_done_a", {15'd0, done_v[1]}, 16'd1);
      chk("l1_dout_a", dout_a[1], 16'h00AA);
      addr_a[1] = 16'h0002;
      #1 chk("l1_done_stall", {15'd0, stall_v[1]}, 16'd0);
      @(negedge clk);
      chk("l1_gap_done", {15'd0, done_v[1]},  16'd0);
      chk("l1_gap_busy", {15'd0, busy_v[1]},  16'd0);
      chk("l1_gap_dout", dout_a[1], 16'h00AA);
      @(negedge clk);
      chk("l1_done_b", {15'd0, done_v[1]}, 16'd1);
      chk("l1_dout_b", dout_a[1], 16'h0055);
      rd_v[1] = 1'b0;
      exp_dout[1] = 16'h0055;
      @(negedge clk);
      idle_chk(1);

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned store is skipped and flagged with done.
      do_op(0, 1'b1, 16'h0011, 16'hFFFF, 1'b0);
      do_op(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
      chk("align_keep", dout_a[0], 16'hBEEF);
`endif

      // Randomized traffic: prefill a pool of words, then mixed loads/stores
      // with random high address bits and input churn during BUSY.
      for (int i = 0; i < 8; i++) begin
         a = 16'((i * 37) << 1);
         do_op(0, 1'b1, a, 16'($urandom), 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
         widx = $urandom_range(0, 7) * 37;
         wr   = 1'($urandom);
         a    = {5'($urandom), 10'(widx), 1'b0};
`ifndef MEM_ALIGN_CHECK_EN
         a[0] = 1'($urandom);
`endif
         do_op(0, wr, a, 16'($urandom), 1'b1);
      end
      for (int i = 0; i < 10; i++) begin
         a = {5'($urandom), 10'($urandom_range(0, 1)), 1'b0};
         do_op(1, 1'($urandom), a, 16'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
